// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage pipeline
// Merges load-use, memory wait and branch redirects; data-memory watchdog; perf counters.
module pipeline_stall_controller #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    localparam logic [9:0] LP_LAST_WAIT = 10'(TIMEOUT - 1);

    state_t           r_state;
    logic [9:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic w_dmem_busy;
    logic w_branch_rule;

    assign w_dmem_busy = mem_access & ~dmem_ready;

    // A branch seen while memory is busy is simply outranked: EX is frozen, so the
    // same branch_taken is presented again once the access completes.
    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_flush  = 1'b0;
        mem_timeout   = 1'b0;
        w_branch_rule = 1'b0;
        if (rst) begin
            mem_timeout = 1'b0;
        end else if (r_state == S_ERROR) begin
            mem_timeout = 1'b1;
        end else if (w_dmem_busy) begin
            mem_wb_flush = 1'b1;
        end else if (branch_taken) begin
            w_branch_rule = 1'b1;
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_write   = 1'b1;
            ex_mem_write  = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (load_use_stall) begin
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (!imem_ready) begin
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_id_flush  = 1'b1;
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_wait_cnt     <= 10'd0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_dmem_busy) begin
                        r_state    <= S_DWAIT;
                        r_wait_cnt <= 10'd1;
                    end
                end
                S_DWAIT: begin
                    if (!w_dmem_busy) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= 10'd0;
                    end else if (r_wait_cnt == LP_LAST_WAIT) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 10'd1;
                    end
                end
                S_ERROR: r_state <= S_ERROR;
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= 10'd0;
                end
            endcase
            if (!pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_branch_rule && (r_flush_count != {CNT_W{1'b1}}))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges the load-use stall request from the hazard detection unit, multi-cycle instruction/data memory wait states and taken-branch redirects into one consistent set of per-stage write-enable and flush controls. Includes a data-memory watchdog with a sticky error state and stall/flush performance counters. Sits beside the hazard detection unit; drives the PC register, all pipeline registers and the control-bubble mux.

## Interface
- TIMEOUT, 64: max consecutive data-memory wait cycles before error; legal range 2..1023.
- CNT_W, 32: width of performance counters.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_use_stall  in  1  stall request from hazard detection unit (its inverted control_write).
- branch_taken  in  1  taken branch/jump resolved in EX this cycle.
- imem_ready  in  1  instruction memory returns valid fetch this cycle.
- mem_access  in  1  EX_MEM stage holds a load or store.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage write enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, control zero) into the register.
- mem_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.
- flush_count  out  CNT_W  count of taken-branch flushes.

## Operation
- Outputs are combinational from inputs and registered state (same-cycle response); state/counters update on clk rising edge.
- dmem_busy = mem_access & ~dmem_ready.
- FSM states: RUN, DWAIT, ERROR.
  - RUN -> DWAIT when dmem_busy; wait_cnt <= 1.
  - DWAIT: dmem_busy -> wait_cnt+1; ~dmem_busy -> RUN, wait_cnt <= 0.
  - DWAIT -> ERROR when dmem_busy and wait_cnt = TIMEOUT-1 (TIMEOUT busy cycles total).
  - ERROR: absorbing; exits only on rst.
- Control priority, highest first:
  1. ERROR: all write enables 0, all flushes 0, mem_timeout=1.
  2. dmem_busy: pc/if_id/id_ex/ex_mem write = 0; mem_wb_flush=1 (no duplicate writeback).
  3. branch_taken: pc_write=1 (target), if_id_flush=1, id_ex_flush=1, others write 1; load_use_stall and imem_ready ignored.
  4. load_use_stall: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1.
  5. ~imem_ready: pc_write=0, if_id_flush=1, all other writes 1.
  6. otherwise: all write enables 1, all flushes 0.
- Flush and write enable to the same register: flush wins (register loads bubble).
- Branch during dmem_busy: held (EX frozen); applied in the first cycle dmem_busy drops.
- stall_cycles: +1 every non-reset cycle with pc_write=0 (incl. ERROR); saturates at all-ones.
- flush_count: +1 per cycle where rule 3 is the active rule; saturates at all-ones.

## Timing
- Reset (rst=1 sampled at edge): state RUN, wait_cnt 0, stall_cycles 0, flush_count 0, mem_timeout 0.
- While rst=1: all write enables 0, all flushes 0, mem_timeout 0; counters do not increment.
- Load-use: exactly one bubble per assertion; stall latency 0 cycles.
- Data access with N wait cycles (dmem_ready low N cycles): pipeline frozen N cycles, releases the cycle dmem_ready=1; N < TIMEOUT never errors.
- dmem_ready=1 in same cycle wait_cnt=TIMEOUT-1: no error, return to RUN.
- mem_access dropping mid-wait: treated as completion, return to RUN.
- rst mid-DWAIT or in ERROR: next cycle RUN, counters cleared.

## Test plan
- Load-use: load_use_stall=1 one cycle, all else ready -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cycles=1 after.
- Branch vs load-use: branch_taken=1 and load_use_stall=1 same cycle -> pc_write=1, if_id_flush=1, id_ex_flush=1; flush_count=1, stall_cycles=0.
- Data wait: mem_access=1, dmem_ready low 3 cycles then high -> 3 cycles all writes 0, mem_wb_flush=1; 4th cycle normal; stall_cycles=3.
- Timeout: TIMEOUT=4, dmem_ready held low -> mem_timeout=1 from 5th cycle, all writes 0 indefinitely; dmem_ready=1 later has no effect; rst clears it.
- Boundary: TIMEOUT=4, dmem_ready rises on 4th busy cycle -> no error, RUN next cycle.
- Imem miss + branch: imem_ready=0 and branch_taken=1 -> pc_write=1, both flushes 1; imem_ready=0 alone -> pc_write=0, if_id_flush=1, id_ex_write=1.
